// File: rtl/maq_ajuste.sv
// maq_ajuste: mode/sequencing controller for the clock's minute and hour counters.
//
// In RUN it divides the 1 Hz seconds tick down to a per-minute increment pulse and
// forwards the minute counter's hour carry. In the two SET states the inc button
// (with auto-repeat) drives the counter being set, and a blink gate blanks its digits.
//
// Ports:
//   maqa_clock           in   system clock, rising edge
//   maqa_reset           in   synchronous, active-high reset
//   maqa_tick_seg        in   one-cycle 1 Hz strobe
//   maqa_btn_modo        in   mode button level (synchronized/debounced)
//   maqa_btn_inc         in   increment button level (synchronized/debounced)
//   maqa_carry_min       in   hour-increment request from the minute counter
//   maqa_min_enable      out  enable to minute counter
//   maqa_min_incremento  out  one-cycle minute increment pulse
//   maqa_hora_enable     out  enable to hour counter
//   maqa_hora_incremento out  one-cycle hour increment pulse
//   maqa_modo            out  00 RUN, 01 SET_HORA, 10 SET_MIN
//   maqa_pisca           out  blink gate for the digits being set (1 = blank)
//
// All outputs are registered: an input sampled at a rising edge is reflected on the
// outputs right after that same edge, and pulses last exactly one cycle.

module maq_ajuste #(
    parameter int unsigned DIV_MIN      = 60,
    parameter int unsigned REPEAT_DELAY = 50000000,
    parameter int unsigned REPEAT_RATE  = 12500000,
    parameter int unsigned BLINK_HALF   = 25000000
) (
    input  logic       maqa_clock,
    input  logic       maqa_reset,
    input  logic       maqa_tick_seg,
    input  logic       maqa_btn_modo,
    input  logic       maqa_btn_inc,
    input  logic       maqa_carry_min,
    output logic       maqa_min_enable,
    output logic       maqa_min_incremento,
    output logic       maqa_hora_enable,
    output logic       maqa_hora_incremento,
    output logic [1:0] maqa_modo,
    output logic       maqa_pisca
);

    localparam int unsigned RepMax  = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned SecW    = $clog2(DIV_MIN);
    localparam int unsigned RepW    = $clog2(RepMax);
    localparam int unsigned BlinkW  = $clog2(BLINK_HALF);

    localparam logic [SecW-1:0]   SecLast      = SecW'(DIV_MIN - 1);
    // Delay pulse fires on the edge where the counter steps onto REPEAT_DELAY-1.
    localparam logic [RepW-1:0]   RepDelayPen  = RepW'(REPEAT_DELAY - 2);
    localparam logic [RepW-1:0]   RepRateLast  = RepW'(REPEAT_RATE - 1);
    localparam logic [BlinkW-1:0] BlinkLast    = BlinkW'(BLINK_HALF - 1);

    typedef enum logic [1:0] {
        StRun     = 2'b00,
        StSetHora = 2'b01,
        StSetMin  = 2'b10
    } estado_t;

    estado_t estado_q, estado_d, estado_ef;

    // Button history and hold-off: a button already high during reset must be seen
    // low once before it can produce a press.
    logic modo_prev_q, inc_prev_q;
    logic modo_trava_q, inc_trava_q;
    logic press_modo, press_inc;

    logic [SecW-1:0]   seg_q, seg_d;
    logic [RepW-1:0]   rep_q, rep_d;
    logic              rep_arm_q, rep_arm_d;   // inc pressed in a SET state and still held
    logic              rep_fase_q, rep_fase_d; // 0: initial delay, 1: steady repeat rate
    logic              rep_pulso;
    logic              inc_evt;
    logic [BlinkW-1:0] blink_q, blink_d;
    logic              pisca_q, pisca_d;

    logic       min_en_q, min_en_d;
    logic       min_inc_q, min_inc_d;
    logic       hora_en_q, hora_en_d;
    logic       hora_inc_q, hora_inc_d;
    logic [1:0] modo_q;

    assign press_modo = maqa_btn_modo & ~modo_prev_q & ~modo_trava_q;
    assign press_inc  = maqa_btn_inc & ~inc_prev_q & ~inc_trava_q;

    // The unused encoding 11 behaves as RUN.
    assign estado_ef = (estado_q == StSetHora || estado_q == StSetMin) ? estado_q : StRun;

    // Auto-repeat engine
    always_comb begin
        rep_d      = rep_q;
        rep_arm_d  = rep_arm_q;
        rep_fase_d = rep_fase_q;
        rep_pulso  = 1'b0;
        if (estado_ef == StRun || press_modo || !maqa_btn_inc) begin
            rep_d      = '0;
            rep_arm_d  = 1'b0;
            rep_fase_d = 1'b0;
        end else if (press_inc) begin
            rep_d      = '0;
            rep_arm_d  = 1'b1;
            rep_fase_d = 1'b0;
        end else if (rep_arm_q) begin
            if (!rep_fase_q) begin
                if (rep_q == RepDelayPen) begin
                    rep_pulso  = 1'b1;
                    rep_fase_d = 1'b1;
                    rep_d      = '0;
                end else begin
                    rep_d = rep_q + RepW'(1);
                end
            end else if (rep_q == RepRateLast) begin
                rep_pulso = 1'b1;
                rep_d     = '0;
            end else begin
                rep_d = rep_q + RepW'(1);
            end
        end
    end

    // A mode press in the same cycle swallows any inc event.
    assign inc_evt = (press_inc | rep_pulso) & ~press_modo;

    // Mode FSM, seconds divider and pulse generation
    always_comb begin
        estado_d   = estado_ef;
        seg_d      = seg_q;
        min_inc_d  = 1'b0;
        hora_inc_d = 1'b0;
        case (estado_ef)
            StSetHora: begin
                hora_inc_d = inc_evt;
                if (press_modo) begin
                    estado_d = StSetMin;
                end
            end
            StSetMin: begin
                min_inc_d = inc_evt;
                if (press_modo) begin
                    estado_d = StRun;
                    seg_d    = '0;
                end
            end
            default: begin
                if (maqa_tick_seg) begin
                    if (seg_q == SecLast) begin
                        seg_d     = '0;
                        min_inc_d = 1'b1;
                    end else begin
                        seg_d = seg_q + SecW'(1);
                    end
                end
                hora_inc_d = maqa_carry_min;
                if (press_modo) begin
                    estado_d = StSetHora;
                end
            end
        endcase
    end

    // Enables and blink follow the state being entered
    always_comb begin
        min_en_d  = 1'b0;
        hora_en_d = 1'b0;
        case (estado_d)
            StSetHora: hora_en_d = 1'b1;
            StSetMin:  min_en_d  = 1'b1;
            default: begin
                min_en_d  = 1'b1;
                hora_en_d = 1'b1;
            end
        endcase

        blink_d = blink_q;
        pisca_d = pisca_q;
        if (estado_d == StRun || press_modo) begin
            blink_d = '0;
            pisca_d = 1'b0;
        end else if (blink_q == BlinkLast) begin
            blink_d = '0;
            pisca_d = ~pisca_q;
        end else begin
            blink_d = blink_q + BlinkW'(1);
        end
    end

    always_ff @(posedge maqa_clock) begin
        if (maqa_reset) begin
            estado_q     <= StRun;
            modo_prev_q  <= 1'b0;
            inc_prev_q   <= 1'b0;
            modo_trava_q <= maqa_btn_modo;
            inc_trava_q  <= maqa_btn_inc;
            seg_q        <= '0;
            rep_q        <= '0;
            rep_arm_q    <= 1'b0;
            rep_fase_q   <= 1'b0;
            blink_q      <= '0;
            pisca_q      <= 1'b0;
            min_en_q     <= 1'b0;
            min_inc_q    <= 1'b0;
            hora_en_q    <= 1'b0;
            hora_inc_q   <= 1'b0;
            modo_q       <= 2'b00;
        end else begin
            estado_q     <= estado_d;
            modo_prev_q  <= maqa_btn_modo;
            inc_prev_q   <= maqa_btn_inc;
            modo_trava_q <= modo_trava_q & maqa_btn_modo;
            inc_trava_q  <= inc_trava_q & maqa_btn_inc;
            seg_q        <= seg_d;
            rep_q        <= rep_d;
            rep_arm_q    <= rep_arm_d;
            rep_fase_q   <= rep_fase_d;
            blink_q      <= blink_d;
            pisca_q      <= pisca_d;
            min_en_q     <= min_en_d;
            min_inc_q    <= min_inc_d;
            hora_en_q    <= hora_en_d;
            hora_inc_q   <= hora_inc_d;
            modo_q       <= estado_d;
        end
    end

    assign maqa_min_enable      = min_en_q;
    assign maqa_min_incremento  = min_inc_q;
    assign maqa_hora_enable     = hora_en_q;
    assign maqa_hora_incremento = hora_inc_q;
    assign maqa_modo            = modo_q;
    assign maqa_pisca           = pisca_q;

endmodule

// File: tb/tb_maq_ajuste.sv
// tb_maq_ajuste: self-checking bench for maq_ajuste with small parameters.
// A cycle-level reference model built from elapsed-time arithmetic predicts every
// output after each clock edge; directed scenarios add explicit spot checks.

module tb_maq_ajuste;

    localparam int DIV  = 4;
    localparam int DLY  = 8;
    localparam int RATE = 3;
    localparam int HALF = 5;

    logic       clk = 1'b0;
    logic       rst, tick, b_modo, b_inc, carry;
    logic       min_en, min_inc, hora_en, hora_inc, pisca;
    logic [1:0] modo;
    logic [6:0] obs;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model state
    int         m_cyc = 0;
    int         m_mode = 0;
    int         m_secs = 0;
    int         m_press_t = 0;
    int         m_entry_t = 0;
    bit         m_armed = 0;
    bit         m_prev_modo = 0, m_prev_inc = 0, m_ok_modo = 0, m_ok_inc = 0;
    logic [6:0] exp_out = '0; // {min_en, min_inc, hora_en, hora_inc, modo, pisca}

    maq_ajuste #(
        .DIV_MIN      (DIV),
        .REPEAT_DELAY (DLY),
        .REPEAT_RATE  (RATE),
        .BLINK_HALF   (HALF)
    ) dut (
        .maqa_clock           (clk),
        .maqa_reset           (rst),
        .maqa_tick_seg        (tick),
        .maqa_btn_modo        (b_modo),
        .maqa_btn_inc         (b_inc),
        .maqa_carry_min       (carry),
        .maqa_min_enable      (min_en),
        .maqa_min_incremento  (min_inc),
        .maqa_hora_enable     (hora_en),
        .maqa_hora_incremento (hora_inc),
        .maqa_modo            (modo),
        .maqa_pisca           (pisca)
    );

    assign obs = {min_en, min_inc, hora_en, hora_inc, modo, pisca};

    always #5 clk = ~clk;

    // Predicts the outputs produced by the coming clock edge from the current inputs.
    task automatic model_edge();
        bit mp, ip, ev, mi, hi, pis;
        int k;
        m_cyc++;
        if (rst) begin
            m_mode = 0; m_secs = 0; m_armed = 0;
            m_prev_modo = 0; m_prev_inc = 0;
            m_ok_modo = !b_modo; m_ok_inc = !b_inc;
            exp_out = '0;
            return;
        end
        mp = b_modo && !m_prev_modo && m_ok_modo;
        ip = b_inc && !m_prev_inc && m_ok_inc;
        mi = 0; hi = 0; ev = 0;
        if (m_mode != 0 && !mp && b_inc) begin
            if (ip) begin
                m_armed = 1; m_press_t = m_cyc; ev = 1;
            end else if (m_armed) begin
                k = m_cyc - m_press_t;
                if (k >= DLY - 1 && (k - (DLY - 1)) % RATE == 0) ev = 1;
            end
        end else begin
            m_armed = 0;
        end
        case (m_mode)
            0: begin
                if (tick) begin
                    m_secs++;
                    if (m_secs == DIV) begin m_secs = 0; mi = 1; end
                end
                hi = carry;
            end
            1: hi = ev;
            default: mi = ev;
        endcase
        if (mp) begin
            if (m_mode == 2) m_secs = 0;
            m_mode = (m_mode + 1) % 3;
            m_entry_t = m_cyc;
            m_armed = 0;
        end
        pis = (m_mode != 0) ? (((m_cyc - m_entry_t) / HALF) % 2 == 1) : 1'b0;
        exp_out = {(m_mode != 1), mi, (m_mode != 2), hi, 2'(m_mode), pis};
        m_prev_modo = b_modo; m_prev_inc = b_inc;
        if (!b_modo) m_ok_modo = 1;
        if (!b_inc) m_ok_inc = 1;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1; tick = 0; carry = 0; b_modo = 0; b_inc = 0;
        step(); step();
        rst = 0;
    endtask

    task automatic press_modo();
        b_modo = 1; step();
        b_modo = 0; step();
    endtask

    task automatic test_reset();
        rst = 1; tick = 1; carry = 1; b_modo = 1; b_inc = 1;
        for (int i = 0; i < 2; i++) begin
            step();
            n_chk++;
            if (obs !== 7'b0) begin
                n_fail++;
                $display("FAIL reset_outputs cyc=%0d got=%b want=%b", m_cyc, obs, 7'b0);
            end
        end
        rst = 0; tick = 0; carry = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_chk++;
            if (obs !== exp_out || modo !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_held_btn cyc=%0d got=%b want=%b", m_cyc, obs, exp_out);
            end
        end
        b_modo = 0; b_inc = 0;
        step();
    endtask

    task automatic test_run_ticks();
        int pulses = 0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            tick = 1; step(); tick = 0;
            n_chk++;
            if (obs !== exp_out || min_inc !== (i == 3 || i == 7)) begin
                n_fail++;
                $display("FAIL run_tick%0d got=%b want=%b", i, obs, exp_out);
            end
            if (min_inc) pulses++;
            step();
            if (min_inc) pulses++;
        end
        n_chk++;
        if (pulses != 2) begin
            n_fail++;
            $display("FAIL run_tick_count got=%0d want=2", pulses);
        end
    endtask

    task automatic test_carry();
        do_reset();
        step();
        carry = 1; step(); carry = 0;
        n_chk++;
        if (obs !== exp_out || hora_inc !== 1'b1) begin
            n_fail++;
            $display("FAIL carry_run got=%b want=%b", obs, exp_out);
        end
        step();
        n_chk++;
        if (hora_inc !== 1'b0) begin
            n_fail++;
            $display("FAIL carry_run_len got=%b want=0", hora_inc);
        end
        press_modo(); press_modo();
        carry = 1; step(); carry = 0;
        n_chk++;
        if (obs !== exp_out || hora_inc !== 1'b0 || modo !== 2'b10) begin
            n_fail++;
            $display("FAIL carry_setmin got=%b want=%b", obs, exp_out);
        end
        press_modo();
    endtask

    task automatic test_mode_walk();
        logic [1:0] want[3] = '{2'b01, 2'b10, 2'b00};
        int pulses = 0;
        do_reset();
        for (int i = 0; i < 2; i++) begin tick = 1; step(); tick = 0; step(); end
        for (int i = 0; i < 3; i++) begin
            b_modo = 1; step(); b_modo = 0;
            n_chk++;
            if (obs !== exp_out || modo !== want[i]) begin
                n_fail++;
                $display("FAIL mode_walk%0d got=%b want=%b", i, modo, want[i]);
            end
            step();
        end
        for (int i = 0; i < 4; i++) begin
            tick = 1; step(); tick = 0;
            n_chk++;
            if (obs !== exp_out) begin
                n_fail++;
                $display("FAIL mode_walk_tick%0d got=%b want=%b", i, obs, exp_out);
            end
            if (min_inc) pulses = (i == 3) ? pulses + 1 : pulses + 10;
            step();
        end
        n_chk++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL mode_walk_fresh got=%0d want=1", pulses);
        end
    endtask

    task automatic test_autorepeat();
        int want[6] = '{1, 8, 11, 14, 17, 20};
        int hits[$];
        bit min_seen = 0;
        do_reset();
        press_modo();
        b_inc = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            n_chk++;
            if (obs !== exp_out) begin
                n_fail++;
                $display("FAIL repeat_cyc%0d got=%b want=%b", i + 1, obs, exp_out);
            end
            if (hora_inc) hits.push_back(i + 1);
            if (min_inc) min_seen = 1;
        end
        b_inc = 0; step();
        n_chk++;
        if (hits.size() != 6 || min_seen) begin
            n_fail++;
            $display("FAIL repeat_count got=%0d want=6 min=%0b", hits.size(), min_seen);
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_chk++;
                if (hits[i] != want[i]) begin
                    n_fail++;
                    $display("FAIL repeat_pos%0d got=%0d want=%0d", i, hits[i], want[i]);
                end
            end
        end
        press_modo(); press_modo();
    endtask

    task automatic test_simultaneous();
        do_reset();
        press_modo(); press_modo();
        for (int k = 2; k < 14; k++) begin
            step();
            n_chk++;
            if (obs !== exp_out || pisca !== ((k / HALF) % 2 == 1)) begin
                n_fail++;
                $display("FAIL blink_k%0d got=%b want=%b", k, obs, exp_out);
            end
        end
        b_modo = 1; b_inc = 1; step(); b_modo = 0;
        n_chk++;
        if (obs !== exp_out || modo !== 2'b00 || min_inc !== 1'b0 || pisca !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_modo_inc got=%b want=%b", obs, exp_out);
        end
        for (int i = 0; i < 12; i++) begin
            step();
            n_chk++;
            if (obs !== exp_out || pisca !== 1'b0) begin
                n_fail++;
                $display("FAIL simul_after%0d got=%b want=%b", i, obs, exp_out);
            end
        end
        b_inc = 0; step();
    endtask

    task automatic test_reset_mid_repeat();
        int late = 0;
        do_reset();
        press_modo(); press_modo();
        b_inc = 1;
        for (int i = 0; i < 10; i++) step();
        rst = 1; step();
        n_chk++;
        if (obs !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_mid got=%b want=%b", obs, 7'b0);
        end
        rst = 0;
        press_modo(); press_modo();
        for (int i = 0; i < 15; i++) begin
            step();
            n_chk++;
            if (obs !== exp_out) begin
                n_fail++;
                $display("FAIL reset_held%0d got=%b want=%b", i, obs, exp_out);
            end
            if (min_inc || hora_inc) late++;
        end
        n_chk++;
        if (late != 0) begin
            n_fail++;
            $display("FAIL reset_no_pulse got=%0d want=0", late);
        end
        b_inc = 0; step();
        b_inc = 1; step();
        n_chk++;
        if (obs !== exp_out || min_inc !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_repress got=%b want=%b", obs, exp_out);
        end
        b_inc = 0; step();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            rst   = ($urandom_range(0, 299) == 0);
            tick  = ($urandom_range(0, 2) == 0);
            carry = ($urandom_range(0, 6) == 0);
            if ($urandom_range(0, 11) == 0) b_modo = ~b_modo;
            if ($urandom_range(0, 14) == 0) b_inc = ~b_inc;
            step();
            n_chk++;
            if (obs !== exp_out) begin
                n_fail++;
                $display("FAIL random cyc=%0d got=%b want=%b", m_cyc, obs, exp_out);
            end
        end
        rst = 0; tick = 0; carry = 0; b_modo = 0; b_inc = 0;
    endtask

    initial begin
        rst = 1; tick = 0; b_modo = 0; b_inc = 0; carry = 0;
        test_reset();
        test_run_ticks();
        test_carry();
        test_mode_walk();
        test_autorepeat();
        test_simultaneous();
        test_reset_mid_repeat();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
